// File: rtl/demux13x16_pkg.sv
// ---------------------------------------------------------------------------
// demux13x16_pkg
// Shared definitions for the 1-to-3 result demultiplexer:
//   - destination select codes carried on cntrl
//   - one-entry slot state encoding
//   - default data width
// Optional feature macro used by the files importing this package:
//   DEMUX_CNT_EN  -> per-port saturating transfer counters
// ---------------------------------------------------------------------------
package demux13x16_pkg;

    // Destination select codes; 2'b11 aliases port 1 like the mux default arm
    localparam logic [1:0] SEL_P1  = 2'b00;
    localparam logic [1:0] SEL_P2  = 2'b01;
    localparam logic [1:0] SEL_P3  = 2'b10;
    localparam logic [1:0] SEL_P1B = 2'b11;

    // One-entry holding slot state
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

    localparam int WIDTH_DEF = 16;

endpackage : demux13x16_pkg

// File: rtl/demux13x16_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One-entry register slice for a single demux destination.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   load         a word routed to this slot is accepted this cycle
//   din          word to capture on load
//   rdy          consumer takes the held word this cycle (ignored when empty)
//   dout, vld    held word and slot-full flag (both straight from flops)
//   free         slot can take a word this cycle (empty, or draining now)
//   cnt          accepted-word count, saturating (only with DEMUX_CNT_EN)
// The top only asserts load when free is high, so a load into a FULL slot
// always coincides with a drain.
// ---------------------------------------------------------------------------
module demux_slot
    import demux13x16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             rdy,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic             free
`ifdef DEMUX_CNT_EN
    , output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Slot next-state and held-word update
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            ST_EMPTY: begin
                if (load) state_d = ST_FULL;
                else      state_d = ST_EMPTY;
            end
            ST_FULL: begin
                // a reload in the same cycle as a drain keeps the slot full
                if (load)     state_d = ST_FULL;
                else if (rdy) state_d = ST_EMPTY;
                else          state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
        // the word is kept after drain; only a new load replaces it
        if (load) data_d = din;
        else      data_d = data_q;
    end

    // Slot state and data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign vld  = (state_q == ST_FULL);
    assign dout = data_q;
    assign free = (state_q == ST_EMPTY) | rdy;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of words accepted into this slot
    always_comb begin
        cnt_d = cnt_q;
        if (load && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        else                                   cnt_d = cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= {CNT_W{1'b0}};
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
`endif

endmodule : demux_slot

// File: rtl/demux13x16.sv
// ---------------------------------------------------------------------------
// demux13x16
// Registered 1-to-3 demultiplexer for datapath result words; inverse of the
// 3:1 operand mux. Each destination owns a one-entry slot with valid/ready,
// so a stalled consumer only blocks words aimed at it.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   cntrl                  01 -> port 2, 10 -> port 3, 00/11 -> port 1
//   din, in_valid          input word and its qualifier
//   in_ready               combinational: selected slot empty or draining
//   dout1..3, vld1..3      held word and valid per destination
//   rdy1..3                per-destination consume strobe
//   cnt1..3                per-port saturating accept counts
// Optional feature: define DEMUX_CNT_EN to add the cnt1..3 ports/counters.
// ---------------------------------------------------------------------------
module demux13x16
    import demux13x16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cntrl,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             vld1,
    output logic             vld2,
    output logic             vld3,
    input  logic             rdy1,
    input  logic             rdy2,
    input  logic             rdy3
`ifdef DEMUX_CNT_EN
    , output logic [CNT_W-1:0] cnt1
    , output logic [CNT_W-1:0] cnt2
    , output logic [CNT_W-1:0] cnt3
`endif
);

    logic [2:0] sel_s;
    logic [2:0] free_s;
    logic [2:0] load_s;
    logic       accept_s;

    // One-hot destination decode of cntrl
    always_comb begin
        sel_s = 3'b001;
        case (cntrl)
            SEL_P2:          sel_s = 3'b010;
            SEL_P3:          sel_s = 3'b100;
            SEL_P1, SEL_P1B: sel_s = 3'b001;
            default:         sel_s = 3'b001;
        endcase
    end

    // rdyN reaches in_ready combinationally so a draining slot can refill
    assign in_ready = |(sel_s & free_s);
    assign accept_s = in_valid & in_ready;
    assign load_s   = sel_s & {3{accept_s}};

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) u_slot1 (
        .clk (clk), .reset (reset), .load (load_s[0]), .din (din), .rdy (rdy1),
        .dout (dout1), .vld (vld1), .free (free_s[0])
`ifdef DEMUX_CNT_EN
        , .cnt (cnt1)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) u_slot2 (
        .clk (clk), .reset (reset), .load (load_s[1]), .din (din), .rdy (rdy2),
        .dout (dout2), .vld (vld2), .free (free_s[1])
`ifdef DEMUX_CNT_EN
        , .cnt (cnt2)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) u_slot3 (
        .clk (clk), .reset (reset), .load (load_s[2]), .din (din), .rdy (rdy3),
        .dout (dout3), .vld (vld3), .free (free_s[2])
`ifdef DEMUX_CNT_EN
        , .cnt (cnt3)
`endif
    );

endmodule : demux13x16

// File: tb/tb_demux13x16.sv
// ---------------------------------------------------------------------------
// tb_demux13x16
// Self-checking bench for demux13x16: a table of hand-derived vectors,
// hand-written multi-cycle sequences, and randomized traffic compared with a
// per-port one-word-buffer reference model.
// ---------------------------------------------------------------------------
module tb_demux13x16;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [1:0]  cntrl;
    logic [15:0] din, dout1, dout2, dout3;
    logic        vld1, vld2, vld3, rdy1, rdy2, rdy3;
`ifdef DEMUX_CNT_EN
    logic [3:0]  cnt1, cnt2, cnt3;
`endif

    always #5 clk = ~clk;

    demux13x16 #(
        .WIDTH (16)
`ifdef DEMUX_CNT_EN
        , .CNT_W (4)
`endif
    ) dut (
        .clk (clk), .reset (reset), .cntrl (cntrl), .din (din),
        .in_valid (in_valid), .in_ready (in_ready),
        .dout1 (dout1), .dout2 (dout2), .dout3 (dout3),
        .vld1 (vld1), .vld2 (vld2), .vld3 (vld3),
        .rdy1 (rdy1), .rdy2 (rdy2), .rdy3 (rdy3)
`ifdef DEMUX_CNT_EN
        , .cnt1 (cnt1), .cnt2 (cnt2), .cnt3 (cnt3)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: each destination is a buffer holding at most one word
    bit          m_full [3];
    logic [15:0] m_data [3];
    int          m_cnt  [3];

    typedef struct {
        bit          rst;
        bit          iv;
        logic [1:0]  c;
        logic [15:0] d;
        logic [2:0]  r;        // {rdy3,rdy2,rdy1}
        bit          chk_rdy;
        bit          exp_rdy;
        logic [2:0]  exp_vld;  // {vld3,vld2,vld1}
        logic [15:0] e1, e2, e3;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int dest(input logic [1:0] c);
        if (c == 2'b01)      return 1;
        else if (c == 2'b10) return 2;
        else                 return 0;
    endfunction

    function automatic bit rdy_of(input int n);
        if (n == 0)      return rdy1;
        else if (n == 1) return rdy2;
        else             return rdy3;
    endfunction

    function automatic bit m_in_ready();
        int p;
        p = dest(cntrl);
        return !m_full[p] || rdy_of(p);
    endfunction

    // advance one clock, updating the model with the inputs seen at the edge
    task automatic tick();
        int          p;
        bit          acc, rst;
        bit          r [3];
        logic [15:0] d;
        p   = dest(cntrl);
        acc = in_valid && m_in_ready();
        rst = reset;
        d   = din;
        r   = '{rdy1, rdy2, rdy3};
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                m_full[n] = 1'b0;
                m_data[n] = 16'h0000;
                m_cnt[n]  = 0;
            end else if (acc && p == n) begin
                m_full[n] = 1'b1;
                m_data[n] = d;
                if (m_cnt[n] < 15) m_cnt[n]++;
            end else if (m_full[n] && r[n]) begin
                m_full[n] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s vld1", tag), 32'(vld1), 32'(m_full[0]));
        check($sformatf("%s vld2", tag), 32'(vld2), 32'(m_full[1]));
        check($sformatf("%s vld3", tag), 32'(vld3), 32'(m_full[2]));
        check($sformatf("%s dout1", tag), 32'(dout1), 32'(m_data[0]));
        check($sformatf("%s dout2", tag), 32'(dout2), 32'(m_data[1]));
        check($sformatf("%s dout3", tag), 32'(dout3), 32'(m_data[2]));
`ifdef DEMUX_CNT_EN
        check($sformatf("%s cnt1", tag), 32'(cnt1), 32'(m_cnt[0]));
        check($sformatf("%s cnt2", tag), 32'(cnt2), 32'(m_cnt[1]));
        check($sformatf("%s cnt3", tag), 32'(cnt3), 32'(m_cnt[2]));
`endif
    endtask

    task automatic drive(input bit rst, input bit iv, input logic [1:0] c,
                         input logic [15:0] d, input logic [2:0] r);
        reset = rst; in_valid = iv; cntrl = c; din = d;
        rdy1 = r[0]; rdy2 = r[1]; rdy3 = r[2];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int n = 0; n < 3; n++) begin
            m_full[n] = 1'b0; m_data[n] = 16'h0000; m_cnt[n] = 0;
        end
        //           rst   iv    c      d         r       chk   rdy   vld     dout1     dout2     dout3
        vecs[0] = '{1'b1, 1'b1, 2'b00, 16'hFFFF, 3'b000, 1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 2'b00, 16'hFFFF, 3'b000, 1'b1, 1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 2'b00, 16'h1111, 3'b000, 1'b1, 1'b1, 3'b001, 16'h1111, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 2'b01, 16'h2222, 3'b000, 1'b1, 1'b1, 3'b011, 16'h1111, 16'h2222, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 2'b10, 16'h3333, 3'b000, 1'b1, 1'b1, 3'b111, 16'h1111, 16'h2222, 16'h3333};
        vecs[5] = '{1'b0, 1'b1, 2'b11, 16'h4444, 3'b000, 1'b1, 1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333};
        vecs[6] = '{1'b0, 1'b1, 2'b11, 16'h4444, 3'b001, 1'b1, 1'b1, 3'b111, 16'h4444, 16'h2222, 16'h3333};
        vecs[7] = '{1'b0, 1'b0, 2'b01, 16'h5555, 3'b000, 1'b1, 1'b0, 3'b111, 16'h4444, 16'h2222, 16'h3333};
        vecs[8] = '{1'b0, 1'b0, 2'b01, 16'h6666, 3'b111, 1'b1, 1'b1, 3'b000, 16'h4444, 16'h2222, 16'h3333};
        vecs[9] = '{1'b0, 1'b0, 2'b10, 16'h7777, 3'b000, 1'b1, 1'b1, 3'b000, 16'h4444, 16'h2222, 16'h3333};

        // table: reset, routing sweep, stall on slot 1, idle inputs
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].c, vecs[i].d, vecs[i].r);
            #1;
            if (vecs[i].chk_rdy) check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d vld", i), 32'({vld3, vld2, vld1}), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d dout1", i), 32'(dout1), 32'(vecs[i].e1));
            check($sformatf("vec%0d dout2", i), 32'(dout2), 32'(vecs[i].e2));
            check($sformatf("vec%0d dout3", i), 32'(dout3), 32'(vecs[i].e3));
        end

        // backpressure on slot 2
        drive(1'b0, 1'b1, 2'b01, 16'hABCD, 3'b000);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'b01, 16'h1000 + 16'(i), 3'b000);
            #1;
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'h0);
            tick();
            check($sformatf("bp%0d dout2", i), 32'(dout2), 32'hABCD);
            check($sformatf("bp%0d vld2", i), 32'(vld2), 32'h1);
        end
        drive(1'b0, 1'b1, 2'b01, 16'hBEEF, 3'b010);
        #1;
        check("bp release in_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp release dout2", 32'(dout2), 32'hBEEF);
        check("bp release vld2", 32'(vld2), 32'h1);

        // streaming into port 3 with its consumer always ready
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 2'b10, 16'(i), 3'b100);
            #1;
            check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'h1);
            tick();
            check($sformatf("stream%0d dout3", i), 32'(dout3), 32'(i));
            check($sformatf("stream%0d vld3", i), 32'(vld3), 32'h1);
        end
        drive(1'b0, 1'b0, 2'b10, 16'h0000, 3'b100);
        tick();
        check("stream end vld3", 32'(vld3), 32'h0);
        check("stream end dout3 kept", 32'(dout3), 32'h00FF);

        // mid-operation reset with a word offered that would otherwise go in
        drive(1'b0, 1'b1, 2'b00, 16'h0A0A, 3'b000);
        tick();
        drive(1'b0, 1'b1, 2'b10, 16'h0C0C, 3'b000);
        tick();
        check("pre-reset vld", 32'({vld3, vld2, vld1}), 32'h7);
        drive(1'b1, 1'b1, 2'b00, 16'hDEAD, 3'b001);
        tick();
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 3'b000);
        check("midreset vld", 32'({vld3, vld2, vld1}), 32'h0);
        check("midreset dout1", 32'(dout1), 32'h0000);
        check("midreset dout3", 32'(dout3), 32'h0000);
        tick();
        check("postreset vld", 32'({vld3, vld2, vld1}), 32'h0);
        check_model("postreset");

`ifdef DEMUX_CNT_EN
        // counter saturation on port 2
        check("cnt2 after reset", 32'(cnt2), 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 2'b01, 16'(i), 3'b010);
            tick();
        end
        check("cnt2 saturated", 32'(cnt2), 32'hF);
        check("cnt1 idle", 32'(cnt1), 32'h0);
        check("cnt3 idle", 32'(cnt3), 32'h0);
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom), 16'($urandom), 3'($urandom));
            #1;
            check($sformatf("rand%0d in_ready", i), 32'(in_ready), 32'(m_in_ready()));
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux13x16

// File: doc/demux13x16.md
Name: demux13x16

Overview:
- Registered 1-to-3 demultiplexer for 16-bit words; the inverse of the 3:1 operand mux (`mux31x16`).
- Routes each input word to one of three destination ports, selected by `cntrl`.
- Each destination has a one-entry holding slot with a valid/ready handshake, so a stalled destination does not corrupt the others.
- Sits between the datapath result bus and its three consumers: register-file write port, memory write-data, I/O.

Parameters:
- WIDTH, 16, data width of input and each output.
- CNT_W, 16, width of per-port transfer counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cntrl  in  2  destination select: 2'b01 -> port 2; 2'b10 -> port 3; 2'b00 and 2'b11 -> port 1.
- din  in  WIDTH  input word.
- in_valid  in  1  din/cntrl are valid this cycle.
- in_ready  out  1  block accepts din this cycle.
- dout1, dout2, dout3  out  WIDTH  held word for each destination.
- vld1, vld2, vld3  out  1  corresponding slot holds a word.
- rdy1, rdy2, rdy3  in  1  corresponding destination consumes the word this cycle.
- cnt1, cnt2, cnt3  out  CNT_W  transfer counts; present only when DEMUX_CNT_EN is defined.

Behaviour:
- Reset (synchronous, sampled on the clk edge while reset=1):
  - all vldN=0, all doutN=16'h0000, all cntN=0.
  - in_ready is combinational and valid during reset.
- Slot FSM, one per port N, states EMPTY and FULL:
  - EMPTY -> FULL on accept targeting N.
  - FULL -> EMPTY on vldN&rdyN with no new accept to N.
  - FULL -> FULL when a drain and an accept to N occur in the same cycle; doutN takes the new word.
- vldN = (state==FULL).
- in_ready = (sel slot EMPTY) | (sel slot FULL & rdyN of that slot), where sel is decoded from the current cntrl. This is a combinational path from rdyN to in_ready.
- Accept = in_valid & in_ready. On accept, the selected doutN <= din next edge. Non-selected slots are unchanged.
- Latency: word accepted at edge k is visible on doutN with vldN=1 after edge k. Sustained throughput is 1 word/cycle per port if its consumer holds rdyN=1.
- doutN is held stable while vldN=1 and rdyN=0. doutN keeps its last value after drain; it is not cleared.
- rdyN while vldN=0 is ignored.
- Simultaneous events:
  - a drain of port A and an accept to port B≠A proceed independently in the same cycle.
  - cntrl/din changing while in_valid=0 have no effect.
- reset asserted mid-transfer overrides everything: pending words are discarded, accept is suppressed.
- cntrl=2'b11 behaves exactly as 2'b00, matching the mux default arm.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cntN increments by 1 on every accept routed to port N.
  - counts saturate at {CNT_W{1'b1}}; no wrap.
  - reset clears them.
- Undefined: cnt ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - select constants SEL_P1=2'b00, SEL_P2=2'b01, SEL_P3=2'b10, SEL_P1B=2'b11.
  - slot state encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
  - default WIDTH=16.
- One sub-module, demux_slot:
  - a one-entry register slice with load, drain, dout, vld and optional saturating counter.
  - instantiated three times; the top holds only the select decode and the in_ready mux.

Test Plan:
- Reset check: assert reset with in_valid=1, din=16'hFFFF -> vld1..3=0, dout1..3=0000, no accept; release -> in_ready=1.
- Routing sweep: cntrl=00,01,10,11 with din=0x1111,0x2222,0x3333,0x4444 and all rdy=0 -> after each edge:
  - dout1=1111 / dout2=2222 / dout3=3333, each with its vld=1.
  - fourth word stalls: in_ready=0 because slot 1 is FULL.
  - raise rdy1 -> 4444 accepted the same cycle and dout1=4444 next edge.
- Backpressure: slot 2 FULL with 0xABCD, rdy2=0, cntrl=01, in_valid=1 for 5 cycles -> in_ready=0, dout2 holds ABCD; rdy2=1 -> new word loads, vld2 stays 1.
- Streaming: rdy3=1 constantly, cntrl=10, din=0..255 back-to-back -> in_ready=1 every cycle; dout3 shows each value exactly one cycle after accept, none dropped.
- Mid-operation reset: slots 1 and 3 FULL, assert reset for 1 cycle -> all vld=0 next edge; a word presented during reset is not accepted.
- With DEMUX_CNT_EN and CNT_W=4: 20 accepts to port 2 -> cnt2=4'hF (saturated); cnt1=cnt3=0.
